// File: rtl/ecpri_tx.sv
// eCPRI RMA response transmitter: 16-byte header plus optional read
// payload streamed from local memory with a 2-entry prefetch buffer.
module ecpri_tx #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              send_write_resp,
    input  logic              send_read_resp,
    input  logic [7:0]        req_rma_id,
    input  logic [15:0]       req_elem_id,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        tx_payload_len,
    output logic              req_ready,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_sop,
    output logic              tx_eop,
    output logic [7:0]        drop_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } state_t;

    state_t state_q, state_d;

    logic              is_rd_q;
    logic [7:0]        id_q;
    logic [15:0]       elem_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;

    logic [3:0] hdr_idx;
    logic [7:0] dat_idx;
    logic [7:0] iss_cnt;

    logic [7:0] fifo [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] occ;
    logic       rd_pend;

    logic accept;
    logic fire;
    logic pop;
    logic push;
    logic has_data;
    logic hdr_last;
    logic dat_last;
    logic [2:0] occ_eff;

    logic [47:0] addr48;
    logic [15:0] pay_size;
    logic [7:0]  hdr_byte;
    logic [1:0]  drop_inc;
    logic [8:0]  drop_sum;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_ready
                     && (send_read_resp || send_write_resp);
    assign fire      = tx_valid && tx_ready;
    assign pop       = fire && (state_q == DATA);
    assign push      = rd_pend;
    assign has_data  = is_rd_q && (len_q != 8'd0);
    assign hdr_last  = (state_q == HDR) && (hdr_idx == 4'd15);
    assign dat_last  = (state_q == DATA)
                     && (dat_idx == len_q - 8'd1);

    // A byte popped this cycle frees its slot for a same-cycle fetch,
    // which keeps the payload contiguous at full rate.
    assign occ_eff = {1'b0, occ} + {2'b00, rd_pend}
                   - {2'b00, pop};

    assign mem_rd_en = (state_q != IDLE) && has_data
                     && (iss_cnt != len_q)
                     && (occ_eff < 3'd2);
    assign mem_addr  = addr_q + ADDR_W'(iss_cnt);

    always_comb begin
        addr48   = 48'(addr_q);
        pay_size = is_rd_q ? (16'd12 + {8'd0, len_q}) : 16'd12;
        hdr_byte = 8'h00;
        case (hdr_idx)
            4'd0:    hdr_byte = 8'h10;
            4'd1:    hdr_byte = 8'h04;
            4'd2:    hdr_byte = pay_size[15:8];
            4'd3:    hdr_byte = pay_size[7:0];
            4'd4:    hdr_byte = id_q;
            4'd5:    hdr_byte = is_rd_q ? 8'h01 : 8'h11;
            4'd6:    hdr_byte = elem_q[15:8];
            4'd7:    hdr_byte = elem_q[7:0];
            4'd8:    hdr_byte = addr48[47:40];
            4'd9:    hdr_byte = addr48[39:32];
            4'd10:   hdr_byte = addr48[31:24];
            4'd11:   hdr_byte = addr48[23:16];
            4'd12:   hdr_byte = addr48[15:8];
            4'd13:   hdr_byte = addr48[7:0];
            4'd14:   hdr_byte = 8'h00;
            default: hdr_byte = len_q;
        endcase
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_sop   = 1'b0;
        tx_eop   = 1'b0;
        unique case (state_q)
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = hdr_byte;
                tx_sop   = (hdr_idx == 4'd0);
                tx_eop   = hdr_last && !has_data;
            end
            DATA: begin
                tx_valid = (occ != 2'd0);
                tx_data  = fifo[rd_ptr];
                tx_eop   = dat_last && (occ != 2'd0);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept)
                    state_d = HDR;
            end
            HDR: begin
                if (fire && hdr_last)
                    state_d = has_data ? DATA : IDLE;
            end
            DATA: begin
                if (pop && dat_last)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            is_rd_q <= 1'b0;
            id_q    <= 8'h00;
            elem_q  <= 16'h0000;
            addr_q  <= '0;
            len_q   <= 8'h00;
        end else if (accept) begin
            is_rd_q <= send_read_resp;
            id_q    <= req_rma_id;
            elem_q  <= req_elem_id;
            addr_q  <= req_addr;
            len_q   <= tx_payload_len;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_idx <= 4'd0;
            dat_idx <= 8'd0;
            iss_cnt <= 8'd0;
        end else if (accept) begin
            hdr_idx <= 4'd0;
            dat_idx <= 8'd0;
            iss_cnt <= 8'd0;
        end else begin
            if (fire && (state_q == HDR))
                hdr_idx <= hdr_idx + 4'd1;
            if (pop)
                dat_idx <= dat_idx + 8'd1;
            if (mem_rd_en)
                iss_cnt <= iss_cnt + 8'd1;
        end
    end

    // Memory data lands one cycle after the strobe; reset drops it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend <= 1'b0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            occ     <= 2'd0;
        end else begin
            rd_pend <= mem_rd_en;
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= mem_rd_data;
    end

    always_comb begin
        if (req_ready)
            drop_inc = {1'b0, send_read_resp && send_write_resp};
        else
            drop_inc = {1'b0, send_read_resp}
                     + {1'b0, send_write_resp};
        drop_sum = {1'b0, drop_cnt} + {7'd0, drop_inc};
    end

    always_ff @(posedge clk) begin
        if (reset)
            drop_cnt <= 8'h00;
        else if (drop_sum[8])
            drop_cnt <= 8'hFF;
        else
            drop_cnt <= drop_sum[7:0];
    end

endmodule

// File: tb/tb_ecpri_tx.sv
// Self-checking bench for ecpri_tx: table rows, hand sequences and
// random frames compared against a frame-level reference model.
module tb_ecpri_tx;

    typedef logic [7:0] bq_t [$];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [7:0]  id;
        logic [15:0] elem;
        logic [7:0]  addr;
        logic [7:0]  len;
        int          mode;
        logic [15:0] exp_ps;
        logic [7:0]  exp_b5;
        int          exp_n;
        logic [7:0]  exp_last;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        send_write_resp;
    logic        send_read_resp;
    logic [7:0]  req_rma_id;
    logic [15:0] req_elem_id;
    logic [7:0]  req_addr;
    logic [7:0]  tx_payload_len;
    logic        req_ready;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_sop;
    logic        tx_eop;
    logic [7:0]  drop_cnt;

    int n_chk;
    int n_pass;
    int exp_drop;

    ecpri_tx #(.ADDR_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .send_write_resp (send_write_resp),
        .send_read_resp  (send_read_resp),
        .req_rma_id      (req_rma_id),
        .req_elem_id     (req_elem_id),
        .req_addr        (req_addr),
        .tx_payload_len  (tx_payload_len),
        .req_ready       (req_ready),
        .mem_rd_en       (mem_rd_en),
        .mem_addr        (mem_addr),
        .mem_rd_data     (mem_rd_data),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .tx_sop          (tx_sop),
        .tx_eop          (tx_eop),
        .drop_cnt        (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: mem[a] = a ^ 0xA5, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en)
            mem_rd_data <= mem_addr ^ 8'hA5;
        else
            mem_rd_data <= 8'($urandom);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        n_chk++;
        if (act === want)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
    endtask

    function automatic int sat(input int a, input int b);
        return (a + b > 255) ? 255 : a + b;
    endfunction

    function automatic bq_t build_frame(input logic rd,
                                        input logic [7:0] id,
                                        input logic [15:0] el,
                                        input logic [7:0] ad,
                                        input logic [7:0] l);
        bq_t q;
        logic [127:0] hdr;
        logic [15:0] ps;
        ps  = 16'(12 + (rd ? int'(l) : 0));
        hdr = {8'h10, 8'h04, ps, id, (rd ? 8'h01 : 8'h11), el,
               40'd0, ad, 8'h00, l};
        for (int i = 0; i < 16; i++)
            q.push_back(hdr[127 - 8*i -: 8]);
        if (rd)
            for (int k = 0; k < int'(l); k++)
                q.push_back(8'((int'(ad) + k) % 256) ^ 8'hA5);
        return q;
    endfunction

    task automatic run_frame(
        input logic rd, input logic wr, input logic [7:0] id,
        input logic [15:0] el, input logic [7:0] ad,
        input logic [7:0] l, input int mode,
        input int p_from, input int p_to,
        input logic p_rd, input logic p_wr,
        output logic [15:0] got_ps, output logic [7:0] got_b5,
        output int got_n, output logic [7:0] got_last);
        bq_t  expq;
        int   n, cyc, rds, dhs, ahead, max_ahead;
        logic prev_stall, done;
        logic [7:0] pd;
        logic psop, peop;
        expq = build_frame(rd, id, el, ad, l);
        got_ps = 16'h0; got_b5 = 8'h0; got_last = 8'h0;
        @(negedge clk);
        send_read_resp  = rd;
        send_write_resp = wr;
        req_rma_id      = id;
        req_elem_id     = el;
        req_addr        = ad;
        tx_payload_len  = l;
        if (rd && wr)
            exp_drop = sat(exp_drop, 1);
        @(negedge clk);
        send_read_resp  = 1'b0;
        send_write_resp = 1'b0;
        n = 0; cyc = 0; rds = 0; dhs = 0; max_ahead = 0;
        prev_stall = 1'b0; done = 1'b0;
        pd = 8'h0; psop = 1'b0; peop = 1'b0;
        while (!done && cyc < 2000) begin
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (cyc % 2 == 0);
                default: tx_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (cyc >= p_from && cyc < p_to) begin
                send_read_resp  = p_rd;
                send_write_resp = p_wr;
                exp_drop = sat(exp_drop, int'(p_rd) + int'(p_wr));
            end else begin
                send_read_resp  = 1'b0;
                send_write_resp = 1'b0;
            end
            #1;
            if (cyc == 0) begin
                chk("latency_valid", tx_valid, 1);
                chk("latency_sop", tx_sop, 1);
            end
            if (prev_stall) begin
                chk("stall_valid", tx_valid, 1);
                chk("stall_data", tx_data, pd);
                chk("stall_sop_eop", {tx_sop, tx_eop}, {psop, peop});
            end
            if (mem_rd_en)
                rds++;
            if (tx_valid && tx_ready) begin
                if (n < expq.size()) begin
                    chk($sformatf("byte%0d", n), tx_data, expq[n]);
                    chk($sformatf("sop_eop%0d", n), {tx_sop, tx_eop},
                        {n == 0, n == expq.size() - 1});
                end else begin
                    chk("extra_byte", n, expq.size());
                end
                if (n == 2) got_ps[15:8] = tx_data;
                if (n == 3) got_ps[7:0]  = tx_data;
                if (n == 5) got_b5       = tx_data;
                if (n >= 16) dhs++;
                got_last = tx_data;
                n++;
                if (tx_eop)
                    done = 1'b1;
            end
            ahead = rds - dhs;
            if (ahead > max_ahead)
                max_ahead = ahead;
            prev_stall = tx_valid && !tx_ready;
            pd = tx_data; psop = tx_sop; peop = tx_eop;
            @(negedge clk);
            cyc++;
        end
        send_read_resp  = 1'b0;
        send_write_resp = 1'b0;
        tx_ready        = 1'b1;
        got_n = n;
        chk("eop_seen", done, 1);
        chk("mem_reads", rds, rd ? int'(l) : 0);
        chk("fetch_ahead_le2", max_ahead <= 2, 1);
        if (mode == 0)
            chk("frame_cycles", cyc, expq.size());
        #1;
        chk("req_ready_after_eop", req_ready, 1);
        chk("drop_cnt", drop_cnt, exp_drop);
    endtask

    vec_t        tbl [6];
    logic [15:0] g_ps;
    logic [7:0]  g_b5;
    logic [7:0]  g_last;
    int          g_n;

    initial begin
        n_chk = 0; n_pass = 0; exp_drop = 0;
        reset = 1'b1;
        send_write_resp = 1'b0;
        send_read_resp  = 1'b0;
        req_rma_id = 8'h0; req_elem_id = 16'h0;
        req_addr = 8'h0; tx_payload_len = 8'h0;
        tx_ready = 1'b1;

        tbl[0] = '{1'b0, 1'b1, 8'h5A, 16'h1234, 8'h40, 8'd8, 0,
                   16'h000C, 8'h11, 16, 8'h08};
        tbl[1] = '{1'b1, 1'b0, 8'h77, 16'hABCD, 8'hFE, 8'd4, 0,
                   16'h0010, 8'h01, 20, 8'hA4};
        tbl[2] = '{1'b1, 1'b0, 8'h77, 16'hABCD, 8'hFE, 8'd4, 1,
                   16'h0010, 8'h01, 20, 8'hA4};
        tbl[3] = '{1'b1, 1'b0, 8'h03, 16'h0001, 8'h10, 8'd0, 0,
                   16'h000C, 8'h01, 16, 8'h00};
        tbl[4] = '{1'b1, 1'b1, 8'h09, 16'h0002, 8'h80, 8'd3, 0,
                   16'h000F, 8'h01, 19, 8'h27};
        tbl[5] = '{1'b1, 1'b0, 8'hC3, 16'hBEEF, 8'h05, 8'd255, 2,
                   16'h010B, 8'h01, 271, 8'hA6};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_sop_eop", {tx_sop, tx_eop}, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_req_ready", req_ready, 1);

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i].rd, tbl[i].wr, tbl[i].id, tbl[i].elem,
                      tbl[i].addr, tbl[i].len, tbl[i].mode,
                      0, 0, 1'b0, 1'b0, g_ps, g_b5, g_n, g_last);
            chk($sformatf("tbl%0d_paysize", i), g_ps, tbl[i].exp_ps);
            chk($sformatf("tbl%0d_byte5", i), g_b5, tbl[i].exp_b5);
            chk($sformatf("tbl%0d_nbytes", i), g_n, tbl[i].exp_n);
            chk($sformatf("tbl%0d_last", i), g_last, tbl[i].exp_last);
        end
        chk("drop_after_both", drop_cnt, 1);

        // Write pulse while busy
        run_frame(1'b1, 1'b0, 8'h21, 16'h4321, 8'h30, 8'd6, 0,
                  3, 4, 1'b0, 1'b1, g_ps, g_b5, g_n, g_last);
        chk("drop_busy_write", drop_cnt, 2);

        // 300 dropped pulses saturate the counter
        run_frame(1'b1, 1'b0, 8'h44, 16'h0F0F, 8'h00, 8'd255, 0,
                  0, 150, 1'b1, 1'b1, g_ps, g_b5, g_n, g_last);
        chk("drop_saturate", drop_cnt, 255);

        // Reset during data byte 2 of an L=8 read
        @(negedge clk);
        send_read_resp = 1'b1;
        req_rma_id = 8'h66; req_elem_id = 16'h5555;
        req_addr = 8'h20; tx_payload_len = 8'd8;
        @(negedge clk);
        send_read_resp = 1'b0;
        tx_ready = 1'b1;
        repeat (18) @(negedge clk);
        #1;
        chk("pre_reset_data2", tx_data, 8'h22 ^ 8'hA5);
        reset = 1'b1;
        send_read_resp = 1'b1;
        @(negedge clk);
        send_read_resp = 1'b0;
        #1;
        chk("midrst_tx_valid", tx_valid, 0);
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_drop_cnt", drop_cnt, 0);
        chk("midrst_mem_rd_en", mem_rd_en, 0);
        reset = 1'b0;
        exp_drop = 0;
        @(negedge clk);
        #1;
        chk("post_rst_idle", {req_ready, tx_valid}, 2'b10);
        chk("post_rst_drop", drop_cnt, 0);
        run_frame(1'b1, 1'b0, 8'h5C, 16'hCAFE, 8'h10, 8'd8, 0,
                  0, 0, 1'b0, 1'b0, g_ps, g_b5, g_n, g_last);

        for (int i = 0; i < 20; i++) begin
            int sel;
            logic rr, ww;
            sel = int'($urandom_range(0, 2));
            rr  = (sel != 1);
            ww  = (sel != 0);
            run_frame(rr, ww, 8'($urandom), 16'($urandom),
                      8'($urandom), 8'($urandom_range(0, 40)),
                      int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 10)),
                      int'($urandom_range(0, 14)),
                      1'($urandom), 1'($urandom),
                      g_ps, g_b5, g_n, g_last);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ecpri_tx.md
# ecpri_tx

Byte-serial eCPRI Remote Memory Access (RMA, message type 0x04) response transmitter. It pairs with the eCPRI receiver. The receiver decodes read and write requests and raises a response request. This block then builds the 16-byte response header and, for reads, streams payload bytes fetched from local memory. Output is a byte stream with valid/ready handshake toward the TX FIFO/MAC.

## Interface
Parameters:
- ADDR_W, 8, local memory address width (1..48).

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- send_write_resp  in  1  single-cycle pulse: request a write response.
- send_read_resp  in  1  single-cycle pulse: request a read response.
- req_rma_id  in  8  Remote Memory Access ID to echo.
- req_elem_id  in  16  Element ID to echo.
- req_addr  in  ADDR_W  start address; zero-extended to 48 bits in the header.
- tx_payload_len  in  8  length L in bytes (0..255).
- req_ready  out  1  high when idle; requests are accepted only when it is high.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory read address.
- mem_rd_data  in  8  read data, valid exactly 1 cycle after mem_rd_en.
- tx_data  out  8  output byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts the byte when tx_valid and tx_ready are both high.
- tx_sop  out  1  first byte of the frame.
- tx_eop  out  1  last byte of the frame.
- drop_cnt  out  8  saturating count of rejected requests.

## Operation
- States and transitions:
  - IDLE goes to HDR on an accepted request.
  - HDR goes to DATA after byte 15 handshakes, when the frame is a read with L>0.
  - HDR goes to IDLE after byte 15 handshakes otherwise.
  - DATA goes to IDLE after the handshake of the last data byte (tx_eop).
- Acceptance:
  - A request is accepted in IDLE; request fields are captured on the same edge.
  - If both pulses are high in IDLE, the read is accepted and the write is dropped.
  - Any pulse arriving outside IDLE is dropped.
  - Each dropped pulse increments drop_cnt, which saturates at 255.
- Header bytes 0..15, big-endian:
  - Byte 0: 0x10.
  - Byte 1: 0x04.
  - Bytes 2-3: payload size = 12 + L for a read, 12 for a write (16-bit, max 0x010B).
  - Byte 4: rma_id.
  - Byte 5: 0x01 for a read response, 0x11 for a write response.
  - Bytes 6-7: elem_id.
  - Bytes 8-13: address.
  - Bytes 14-15: {0x00, L}.
- Write response: header only. L is echoed in bytes 14-15 but no data is sent.
- Read response: L data bytes follow the header.
  - Data byte k comes from mem_addr = req_addr + k, modulo 2^ADDR_W (wraps).
- Prefetch:
  - A 2-entry data buffer; reads start on entry to HDR.
  - mem_rd_en is issued only when buffer occupancy plus reads in flight is less than 2.
  - No read is issued beyond L bytes.
- tx_sop is high with byte 0 only. tx_eop is high with the final byte only.

## Timing
- Reset values:
  - tx_valid=0, tx_data=0x00, tx_sop=0, tx_eop=0.
  - mem_rd_en=0, mem_addr=0, drop_cnt=0.
  - State IDLE, buffer empty; req_ready=1 in the cycle after reset.
- Latency: request pulse at edge N gives tx_valid=1 with byte 0 at cycle N+1.
- With tx_ready held high, the frame is contiguous with no bubbles: 16 cycles for a write or L=0 read, 16+L cycles for a read.
- req_ready returns high the cycle after the eop handshake, giving a 1-cycle minimum gap between frames.
- Stall rule: while tx_valid=1 and tx_ready=0, tx_data, tx_sop and tx_eop hold stable and tx_valid stays high.
- Reset asserted mid-frame:
  - Takes effect on the next edge; the frame is abandoned with no eop.
  - In-flight memory data is discarded; all outputs return to reset values.
- Requests coincident with reset are ignored and not counted.

## Test plan
- Write response: rma_id=0x5A, elem=0x1234, addr=0x40, L=8.
  - Required bytes: 10 04 00 0C 5A 11 12 34 00 00 00 00 00 40 00 08.
  - sop on byte 0, eop on byte 15, mem_rd_en never asserted.
- Read response: L=4, addr=0xFE, memory model mem[a]=a^0xA5, tx_ready=1.
  - Required header: 10 04 00 10 id 01 elem 00 00 00 00 00 FE 00 04.
  - Required data: 5B 5A A5 A4 (address wraps to 0x00).
  - 20 contiguous cycles; eop on 0xA4.
- Same read with tx_ready toggling 1,0,1,0:
  - Identical byte sequence; outputs stable during stalls.
  - Never more than 2 bytes fetched ahead.
- Read with L=0:
  - Header only, bytes 2-3 = 00 0C, byte 5 = 0x01.
  - No mem_rd_en; eop on byte 15.
- Request handling:
  - Simultaneous read and write pulses: read frame sent, drop_cnt=1.
  - A write pulse while busy: drop_cnt=2.
  - 300 dropped pulses: drop_cnt holds at 255.
- Reset mid-frame during data byte 2 of an L=8 read:
  - Next cycle tx_valid=0, req_ready=1, drop_cnt=0.
  - The following request produces a clean frame starting with sop.
